m14k_dspram_ctl: RTL and testbench

Data scratchpad RAM controller sitting directly downstream of the DCC SPRAM interface: it consumes the DSP_* strobe/address/data bus the data cache controller drives and returns DSP_Hit, DSP_Stall, read data and tag-space values. It owns the DSPRAM base/enable register, decodes physical-address hits, and sequences a single-port synchronous SRAM with a configurable number of wait states.

---
 rtl/m14k_dspram_ctl_if.sv | 35 +++
 rtl/m14k_dspram_ctl.sv | 153 +++++++++++++++
 tb/tb_m14k_dspram_ctl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/m14k_dspram_ctl_if.sv
// DCC-to-DSPRAM SPRAM bus: strobes, address and data from the cache controller,
// hit/stall/read data back from the scratchpad controller.
interface m14k_dspram_ctl_if;
    logic [17:0] DSP_TagAddr;
    logic        DSP_TagRdStr;
    logic        DSP_TagWrStr;
    logic [23:0] DSP_TagWrValue;
    logic [23:0] DSP_TagCmpValue;
    logic [17:0] DSP_DataAddr;
    logic        DSP_DataRdStr;
    logic        DSP_DataWrStr;
    logic [3:0]  DSP_DataWrMask;
    logic [31:0] DSP_DataWrValue;
    logic [23:0] DSP_TagRdValue;
    logic [31:0] DSP_DataRdValue;
    logic        DSP_Hit;
    logic        DSP_Stall;
    logic        DSP_Present;
    logic        DSP_ParPresent;
    logic [3:0]  DSP_RPar;

    modport master (
        output DSP_TagAddr, DSP_TagRdStr, DSP_TagWrStr, DSP_TagWrValue, DSP_TagCmpValue,
        output DSP_DataAddr, DSP_DataRdStr, DSP_DataWrStr, DSP_DataWrMask, DSP_DataWrValue,
        input  DSP_TagRdValue, DSP_DataRdValue, DSP_Hit, DSP_Stall,
        input  DSP_Present, DSP_ParPresent, DSP_RPar
    );

    modport slave (
        input  DSP_TagAddr, DSP_TagRdStr, DSP_TagWrStr, DSP_TagWrValue, DSP_TagCmpValue,
        input  DSP_DataAddr, DSP_DataRdStr, DSP_DataWrStr, DSP_DataWrMask, DSP_DataWrValue,
        output DSP_TagRdValue, DSP_DataRdValue, DSP_Hit, DSP_Stall,
        output DSP_Present, DSP_ParPresent, DSP_RPar
    );
endinterface

// File: rtl/m14k_dspram_ctl.sv
// Data scratchpad RAM controller: base/enable register, PA hit decode and
// wait-state sequencing of a single-port synchronous SRAM.
module m14k_dspram_ctl #(
    parameter int          SIZE_LOG2   = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [21:0] BASE_RESET  = 22'h0,
    parameter logic        EN_RESET    = 1'b0
) (
    input  logic                 gclk,
    input  logic                 greset_n,
    m14k_dspram_ctl_if.slave     dsp,
    output logic                 sram_ce,
    output logic                 sram_we,
    output logic [3:0]           sram_be,
    output logic [SIZE_LOG2-3:0] sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);
    localparam int          AW      = SIZE_LOG2 - 2;
    localparam logic [1:0]  WS      = 2'(WAIT_STATES);
    localparam logic [8:0]  SIZE_4K = 9'(1 << (SIZE_LOG2 - 12));

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, RD_DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [21:0]    base_q, base_d;
    logic           en_q, en_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           we_q, we_d;
    logic           wr_hit_q, wr_hit_d;
    logic [23:0]    tag_rd_q, tag_rd_d;
    logic           hit;
    logic           unused_bits;

    // Only the PA bits above the window size take part in the match.
    assign hit = en_q && (dsp.DSP_TagCmpValue[23:SIZE_LOG2-8] == base_q[21:SIZE_LOG2-10]);

    assign unused_bits = ^{dsp.DSP_TagAddr, dsp.DSP_TagCmpValue, dsp.DSP_DataAddr, dsp.DSP_TagWrValue[1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        wr_hit_d   = 1'b0;
        base_d     = base_q;
        en_d       = en_q;
        tag_rd_d   = '0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;

        case (state_q)
            IDLE, RD_DONE: begin
                state_d = IDLE;
                // A write wins over a simultaneous read strobe.
                if (hit && dsp.DSP_DataWrStr) begin
                    sram_ce    = 1'b1;
                    sram_we    = 1'b1;
                    sram_be    = dsp.DSP_DataWrMask;
                    sram_addr  = dsp.DSP_DataAddr[AW-1:0];
                    sram_wdata = dsp.DSP_DataWrValue;
                    addr_d     = dsp.DSP_DataAddr[AW-1:0];
                    be_d       = dsp.DSP_DataWrMask;
                    wdata_d    = dsp.DSP_DataWrValue;
                    we_d       = 1'b1;
                    if (WS == 2'd0) begin
                        wr_hit_d = 1'b1;
                    end else begin
                        state_d = WR_BUSY;
                        cnt_d   = WS;
                    end
                end else if (hit && dsp.DSP_DataRdStr) begin
                    sram_ce   = 1'b1;
                    sram_addr = dsp.DSP_DataAddr[AW-1:0];
                    addr_d    = dsp.DSP_DataAddr[AW-1:0];
                    be_d      = '0;
                    wdata_d   = '0;
                    we_d      = 1'b0;
                    if (WS == 2'd0) begin
                        state_d = RD_DONE;
                    end else begin
                        state_d = RD_BUSY;
                        cnt_d   = WS;
                    end
                end
            end
            RD_BUSY, WR_BUSY: begin
                sram_ce    = 1'b1;
                sram_we    = we_q;
                sram_be    = be_q;
                sram_addr  = addr_q;
                sram_wdata = wdata_q;
                cnt_d      = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d  = (state_q == RD_BUSY) ? RD_DONE : IDLE;
                    wr_hit_d = (state_q == WR_BUSY);
                end
            end
            default: state_d = IDLE;
        endcase

        if (dsp.DSP_TagWrStr && !dsp.DSP_TagAddr[2]) begin
            base_d = dsp.DSP_TagWrValue[23:2];
            en_d   = dsp.DSP_TagWrValue[0];
        end

        if (dsp.DSP_TagRdStr) begin
            tag_rd_d = dsp.DSP_TagAddr[2] ? {3'b0, SIZE_4K, 12'b0} : {base_q, 1'b0, en_q};
        end
    end

    always_ff @(posedge gclk or negedge greset_n) begin
        if (!greset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= BASE_RESET;
            en_q     <= EN_RESET;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wr_hit_q <= 1'b0;
            tag_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wr_hit_q <= wr_hit_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    assign dsp.DSP_Hit         = (state_q == RD_DONE) || wr_hit_q;
    assign dsp.DSP_DataRdValue = (state_q == RD_DONE) ? sram_rdata : 32'h0;
    assign dsp.DSP_Stall       = (state_q == RD_BUSY) || (state_q == WR_BUSY);
    assign dsp.DSP_TagRdValue  = tag_rd_q;
    assign dsp.DSP_Present     = 1'b1;
    assign dsp.DSP_ParPresent  = 1'b0;
    assign dsp.DSP_RPar        = 4'h0;
endmodule

// File: tb/tb_m14k_dspram_ctl.sv
// Directed bench: one controller with zero wait states and one with two,
// each backed by a registered-read SRAM model; stimulus shared, strobes steered by sel.
module tb_m14k_dspram_ctl;
    logic        clk = 1'b0;
    logic        greset_n;
    logic [17:0] tag_addr, daddr;
    logic        tag_rd, tag_wr, rd, wr, sel;
    logic [23:0] tag_wr_val, cmp;
    logic [3:0]  mask;
    logic [31:0] wval;

    int checks = 0;
    int errors = 0;
    int stall0_highs = 0;

    always #5 clk = ~clk;

    m14k_dspram_ctl_if ifc0 ();
    m14k_dspram_ctl_if ifc1 ();

    assign ifc0.DSP_TagAddr = tag_addr;       assign ifc1.DSP_TagAddr = tag_addr;
    assign ifc0.DSP_TagRdStr = tag_rd;        assign ifc1.DSP_TagRdStr = tag_rd;
    assign ifc0.DSP_TagWrStr = tag_wr;        assign ifc1.DSP_TagWrStr = tag_wr;
    assign ifc0.DSP_TagWrValue = tag_wr_val;  assign ifc1.DSP_TagWrValue = tag_wr_val;
    assign ifc0.DSP_TagCmpValue = cmp;        assign ifc1.DSP_TagCmpValue = cmp;
    assign ifc0.DSP_DataAddr = daddr;         assign ifc1.DSP_DataAddr = daddr;
    assign ifc0.DSP_DataWrMask = mask;        assign ifc1.DSP_DataWrMask = mask;
    assign ifc0.DSP_DataWrValue = wval;       assign ifc1.DSP_DataWrValue = wval;
    assign ifc0.DSP_DataRdStr = rd & ~sel;    assign ifc1.DSP_DataRdStr = rd & sel;
    assign ifc0.DSP_DataWrStr = wr & ~sel;    assign ifc1.DSP_DataWrStr = wr & sel;

    logic        ce0, we0, ce1, we1;
    logic [3:0]  be0, be1;
    logic [13:0] addr0, addr1;
    logic [31:0] wdata0, wdata1, rdata0, rdata1;
    logic [31:0] mem0 [0:16383];
    logic [31:0] mem1 [0:16383];

    m14k_dspram_ctl #(.SIZE_LOG2(16), .WAIT_STATES(0), .BASE_RESET(22'h0), .EN_RESET(1'b0)) dut0 (
        .gclk(clk), .greset_n(greset_n), .dsp(ifc0),
        .sram_ce(ce0), .sram_we(we0), .sram_be(be0), .sram_addr(addr0),
        .sram_wdata(wdata0), .sram_rdata(rdata0)
    );

    m14k_dspram_ctl #(.SIZE_LOG2(16), .WAIT_STATES(2), .BASE_RESET(22'h0), .EN_RESET(1'b0)) dut1 (
        .gclk(clk), .greset_n(greset_n), .dsp(ifc1),
        .sram_ce(ce1), .sram_we(we1), .sram_be(be1), .sram_addr(addr1),
        .sram_wdata(wdata1), .sram_rdata(rdata1)
    );

    always @(posedge clk) begin
        if (ce0) begin
            if (we0) begin
                for (int b = 0; b < 4; b++) if (be0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
            end else begin
                rdata0 <= mem0[addr0];
            end
        end
        if (ce1) begin
            if (we1) begin
                for (int b = 0; b < 4; b++) if (be1[b]) mem1[addr1][8*b +: 8] <= wdata1[8*b +: 8];
            end else begin
                rdata1 <= mem1[addr1];
            end
        end
    end

    always @(negedge clk) if (ifc0.DSP_Stall === 1'b1) stall0_highs++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        rdata0 = '0; rdata1 = '0;
        greset_n = 1'b0; sel = 1'b0;
        tag_addr = '0; tag_rd = 1'b0; tag_wr = 1'b0; tag_wr_val = '0;
        cmp = '0; daddr = '0; rd = 1'b0; wr = 1'b0; mask = '0; wval = '0;

        nxt(); nxt(); #1;
        chk("rst_stall", 32'(ifc0.DSP_Stall), 32'd0);
        chk("rst_hit", 32'(ifc0.DSP_Hit), 32'd0);
        chk("rst_ce", 32'(ce0), 32'd0);
        chk("rst_tagrd", 32'(ifc0.DSP_TagRdValue), 32'd0);
        chk("rst_rdval", ifc0.DSP_DataRdValue, 32'd0);
        chk("rst_present", 32'(ifc0.DSP_Present), 32'd1);
        chk("rst_parpresent", 32'(ifc0.DSP_ParPresent), 32'd0);
        chk("rst_rpar", 32'(ifc1.DSP_RPar), 32'd0);
        nxt(); greset_n = 1'b1;

        // Base PA 0x0040_0000, enabled; then a write to the size word that must be ignored
        nxt(); tag_wr = 1'b1; tag_addr = 18'h0; tag_wr_val = 24'h004001;
        nxt(); tag_addr = 18'h4; tag_wr_val = 24'hFFFFFF;
        nxt(); tag_wr = 1'b0; tag_rd = 1'b1; tag_addr = 18'h0;
        nxt(); tag_addr = 18'h4; #1;
        chk("tag_base0", 32'(ifc0.DSP_TagRdValue), 32'h004001);
        chk("tag_base1", 32'(ifc1.DSP_TagRdValue), 32'h004001);
        nxt(); tag_rd = 1'b0; #1;
        chk("tag_size", 32'(ifc0.DSP_TagRdValue), 32'h010000);

        // Zero wait states: write then read PA 0x0040_0010
        nxt(); cmp = 24'h004000; daddr = 18'h4; wr = 1'b1; mask = 4'hF; wval = 32'hDEADBEEF; #1;
        chk("ws0_wr_ce", 32'(ce0), 32'd1);
        chk("ws0_wr_we", 32'(we0), 32'd1);
        chk("ws0_wr_addr", 32'(addr0), 32'd4);
        nxt(); wr = 1'b0; rd = 1'b1; #1;
        chk("ws0_wr_hit", 32'(ifc0.DSP_Hit), 32'd1);
        chk("ws0_rd_ce", 32'(ce0), 32'd1);
        chk("ws0_rd_we", 32'(we0), 32'd0);
        nxt(); rd = 1'b0; #1;
        chk("ws0_rd_hit", 32'(ifc0.DSP_Hit), 32'd1);
        chk("ws0_rd_data", ifc0.DSP_DataRdValue, 32'hDEADBEEF);
        nxt(); #1;
        chk("ws0_idle_hit", 32'(ifc0.DSP_Hit), 32'd0);
        chk("ws0_idle_data", ifc0.DSP_DataRdValue, 32'd0);

        // Back-to-back reads
        nxt(); daddr = 18'h5; wr = 1'b1; wval = 32'h12345678;
        nxt(); wr = 1'b0; rd = 1'b1; daddr = 18'h4;
        nxt(); daddr = 18'h5; #1;
        chk("b2b_data1", ifc0.DSP_DataRdValue, 32'hDEADBEEF);
        chk("b2b_ce2", 32'(ce0), 32'd1);
        nxt(); rd = 1'b0; #1;
        chk("b2b_hit2", 32'(ifc0.DSP_Hit), 32'd1);
        chk("b2b_data2", ifc0.DSP_DataRdValue, 32'h12345678);

        // Index bits above the 64KB window are dropped
        nxt(); rd = 1'b1; daddr = 18'h10004; #1;
        chk("wrap_addr", 32'(addr0), 32'd4);
        nxt(); rd = 1'b0; #1;
        chk("wrap_data", ifc0.DSP_DataRdValue, 32'hDEADBEEF);

        // Miss at PA 0x0050_0000
        nxt(); rd = 1'b1; cmp = 24'h005000; daddr = 18'h0; #1;
        chk("miss_ce", 32'(ce0), 32'd0);
        nxt(); rd = 1'b0; #1;
        chk("miss_hit", 32'(ifc0.DSP_Hit), 32'd0);
        chk("miss_stall", 32'(ifc0.DSP_Stall), 32'd0);
        chk("miss_data", ifc0.DSP_DataRdValue, 32'd0);

        // Byte-lane write merged with simultaneous read strobe
        nxt(); cmp = 24'h004000; daddr = 18'h8; wr = 1'b1; mask = 4'hF; wval = 32'h11223344;
        nxt(); mask = 4'b0010; wval = 32'h0000AB00; rd = 1'b1; #1;
        chk("rdwr_we", 32'(we0), 32'd1);
        chk("rdwr_be", 32'(be0), 32'h2);
        nxt(); wr = 1'b0; rd = 1'b0; #1;
        chk("rdwr_hit", 32'(ifc0.DSP_Hit), 32'd1);
        chk("rdwr_noread", ifc0.DSP_DataRdValue, 32'd0);
        nxt(); rd = 1'b1;
        nxt(); rd = 1'b0; #1;
        chk("byte_merge", ifc0.DSP_DataRdValue, 32'h1122AB44);

        // Two wait states: write
        nxt(); sel = 1'b1; daddr = 18'h4; wr = 1'b1; mask = 4'hF; wval = 32'hCAFEF00D; #1;
        chk("ws2_wr_ce", 32'(ce1), 32'd1);
        nxt(); wr = 1'b0; #1;
        chk("ws2_wr_stall1", 32'(ifc1.DSP_Stall), 32'd1);
        chk("ws2_wr_we1", 32'(we1), 32'd1);
        nxt(); #1;
        chk("ws2_wr_stall2", 32'(ifc1.DSP_Stall), 32'd1);
        chk("ws2_wr_nohit", 32'(ifc1.DSP_Hit), 32'd0);
        nxt(); #1;
        chk("ws2_wr_stall3", 32'(ifc1.DSP_Stall), 32'd0);
        chk("ws2_wr_hit", 32'(ifc1.DSP_Hit), 32'd1);
        chk("ws2_wr_ce_off", 32'(ce1), 32'd0);

        // Two wait states: read
        nxt(); rd = 1'b1; #1;
        chk("ws2_rd_addr0", 32'(addr1), 32'd4);
        chk("ws2_rd_stall0", 32'(ifc1.DSP_Stall), 32'd0);
        nxt(); rd = 1'b0; daddr = 18'h0; #1;
        chk("ws2_rd_stall1", 32'(ifc1.DSP_Stall), 32'd1);
        chk("ws2_rd_addr1", 32'(addr1), 32'd4);
        chk("ws2_rd_nohit", 32'(ifc1.DSP_Hit), 32'd0);
        nxt(); #1;
        chk("ws2_rd_stall2", 32'(ifc1.DSP_Stall), 32'd1);
        chk("ws2_rd_addr2", 32'(addr1), 32'd4);
        nxt(); #1;
        chk("ws2_rd_stall3", 32'(ifc1.DSP_Stall), 32'd0);
        chk("ws2_rd_hit", 32'(ifc1.DSP_Hit), 32'd1);
        chk("ws2_rd_data", ifc1.DSP_DataRdValue, 32'hCAFEF00D);
        nxt(); #1;
        chk("ws2_rd_after", 32'(ifc1.DSP_Hit), 32'd0);

        // Reset while a read is in RD_BUSY
        nxt(); daddr = 18'h4; rd = 1'b1;
        nxt(); rd = 1'b0; #1;
        chk("arst_pre_stall", 32'(ifc1.DSP_Stall), 32'd1);
        #1 greset_n = 1'b0; #1;
        chk("arst_stall", 32'(ifc1.DSP_Stall), 32'd0);
        chk("arst_ce", 32'(ce1), 32'd0);
        nxt(); #1;
        chk("arst_noce", 32'(ce1), 32'd0);
        nxt(); greset_n = 1'b1;
        nxt(); tag_rd = 1'b1; tag_addr = 18'h0;
        nxt(); tag_rd = 1'b0; #1;
        chk("arst_base", 32'(ifc1.DSP_TagRdValue), 32'd0);
        nxt(); rd = 1'b1; cmp = 24'h004000; daddr = 18'h4; #1;
        chk("arst_en_miss", 32'(ce1), 32'd0);
        nxt(); rd = 1'b0; #1;
        chk("ws0_never_stall", 32'(stall0_highs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
